// File: rtl/sspm_backbone.sv
// Time-division shared scratchpad: one connector port is served per cycle
// in fixed round-robin slot order; responses come back one cycle later.
module sspm_backbone #(
    parameter int NCORES = 3,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    localparam int BE_W = DATA_W / 8,
    localparam int SLOT_W = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3*NCORES-1:0]      io_m_cmd,
    input  logic [ADDR_W*NCORES-1:0] io_m_addr,
    input  logic [DATA_W*NCORES-1:0] io_m_data,
    input  logic [BE_W*NCORES-1:0]   io_m_byteen,
    output logic [NCORES-1:0]        io_s_cmdaccept,
    output logic [2*NCORES-1:0]      io_s_resp,
    output logic [DATA_W*NCORES-1:0] io_s_data,
    output logic [SLOT_W-1:0]        io_slot
);

    localparam logic [2:0] CMD_WR = 3'b001;
    localparam logic [2:0] CMD_RD = 3'b010;
    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA = 2'b01;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NCORES - 1);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [SLOT_W-1:0] slot;
    logic [2:0]        cmd_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] data_sel;
    logic [BE_W-1:0]   be_sel;
    logic              is_wr;
    logic              is_rd;
    logic              acc;

    logic              rsp_vld;
    logic [SLOT_W-1:0] rsp_port;
    logic [DATA_W-1:0] rsp_data;

    always_comb begin
        cmd_sel  = '0;
        addr_sel = '0;
        data_sel = '0;
        be_sel   = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (slot == SLOT_W'(k)) begin
                cmd_sel  = io_m_cmd[3*k +: 3];
                addr_sel = io_m_addr[ADDR_W*k +: ADDR_W];
                data_sel = io_m_data[DATA_W*k +: DATA_W];
                be_sel   = io_m_byteen[BE_W*k +: BE_W];
            end
        end
    end

    // Gating with reset keeps accepts and memory writes off while held in reset.
    assign is_wr = reset && (cmd_sel == CMD_WR);
    assign is_rd = reset && (cmd_sel == CMD_RD);
    assign acc   = is_wr || is_rd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot <= '0;
        end else if (slot == SLOT_LAST) begin
            slot <= '0;
        end else begin
            slot <= slot + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (is_wr) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_sel[i]) begin
                    mem[addr_sel][8*i +: 8] <= data_sel[8*i +: 8];
                end
            end
        end
    end

    // Only one access per cycle, so a read always sees the previous slot's write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_vld  <= 1'b0;
            rsp_port <= '0;
            rsp_data <= '0;
        end else begin
            rsp_vld  <= acc;
            rsp_port <= slot;
            rsp_data <= is_rd ? mem[addr_sel] : '0;
        end
    end

    always_comb begin
        io_s_cmdaccept = '0;
        io_s_resp      = '0;
        io_s_data      = '0;
        for (int k = 0; k < NCORES; k++) begin
            io_s_cmdaccept[k] = acc && (slot == SLOT_W'(k));
            if (rsp_vld && (rsp_port == SLOT_W'(k))) begin
                io_s_resp[2*k +: 2]      = RESP_DVA;
                io_s_data[DATA_W*k +: DATA_W] = rsp_data;
            end else begin
                io_s_resp[2*k +: 2]      = RESP_NULL;
                io_s_data[DATA_W*k +: DATA_W] = '0;
            end
        end
    end

    assign io_slot = slot;

endmodule

// File: tb/tb_sspm_backbone.sv
// Randomized bench for sspm_backbone against a slot/memory reference model,
// plus directed scenarios for ordering, merging, invalid commands and reset.
module tb_sspm_backbone;

    localparam int NC = 3;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3*NC-1:0]  m_cmd;
    logic [AW*NC-1:0] m_addr;
    logic [DW*NC-1:0] m_data;
    logic [BW*NC-1:0] m_be;
    logic [NC-1:0]    s_acc;
    logic [2*NC-1:0]  s_resp;
    logic [DW*NC-1:0] s_data;
    logic [SW-1:0]    slot;

    logic [2:0]    cmd  [NC];
    logic [AW-1:0] addr [NC];
    logic [DW-1:0] wdat [NC];
    logic [BW-1:0] be   [NC];

    always_comb begin
        m_cmd  = '0;
        m_addr = '0;
        m_data = '0;
        m_be   = '0;
        for (int k = 0; k < NC; k++) begin
            m_cmd[3*k +: 3]    = cmd[k];
            m_addr[AW*k +: AW] = addr[k];
            m_data[DW*k +: DW] = wdat[k];
            m_be[BW*k +: BW]   = be[k];
        end
    end

    sspm_backbone #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk),
        .reset(reset),
        .io_m_cmd(m_cmd),
        .io_m_addr(m_addr),
        .io_m_data(m_data),
        .io_m_byteen(m_be),
        .io_s_cmdaccept(s_acc),
        .io_s_resp(s_resp),
        .io_s_data(s_data),
        .io_slot(slot)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit rnd_mode = 0;
    int last_acc;
    logic [DW-1:0] mdl [16];
    bit            pend_v [NC];
    logic [DW-1:0] pend_d [NC];
    bit            obs_v [NC];
    logic [DW-1:0] obs_d [NC];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit valid_cmd(logic [2:0] c);
        return (c == 3'b001) || (c == 3'b010);
    endfunction

    task automatic new_req(int k);
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) cmd[k] = 3'b010;
        else if (r < 7) cmd[k] = 3'b001;
        else if (r < 9) cmd[k] = 3'b000;
        else cmd[k] = 3'($urandom_range(3, 7));
        addr[k] = AW'($urandom_range(0, 15));
        wdat[k] = $urandom;
        be[k]   = BW'($urandom_range(0, 15));
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, then
    // let the masters react to what was accepted.
    task automatic step();
        int s;
        bit in_rst;
        logic [DW-1:0] w;
        last_acc = -1;
        @(negedge clk);
        in_rst = !reset;
        for (int k = 0; k < NC; k++) begin
            obs_v[k] = (s_resp[2*k +: 2] == 2'b01);
            obs_d[k] = s_data[DW*k +: DW];
        end
        if (in_rst) begin
            chk("slot_rst", 64'(slot), 64'd0);
            for (int k = 0; k < NC; k++) begin
                chk($sformatf("acc_rst%0d", k), 64'(s_acc[k]), 64'd0);
                chk($sformatf("resp_rst%0d", k), 64'(s_resp[2*k +: 2]), 64'd0);
                chk($sformatf("data_rst%0d", k), 64'(s_data[DW*k +: DW]), 64'd0);
                pend_v[k] = 0;
                pend_d[k] = '0;
            end
        end else begin
            s = cyc % NC;
            chk("slot", 64'(slot), 64'(s));
            for (int k = 0; k < NC; k++) begin
                chk($sformatf("acc%0d", k), 64'(s_acc[k]),
                    64'((k == s) && valid_cmd(cmd[k])));
                chk($sformatf("resp%0d", k), 64'(s_resp[2*k +: 2]),
                    pend_v[k] ? 64'd1 : 64'd0);
                chk($sformatf("data%0d", k), 64'(s_data[DW*k +: DW]),
                    64'(pend_d[k]));
                pend_v[k] = 0;
                pend_d[k] = '0;
            end
            if (valid_cmd(cmd[s])) begin
                last_acc = s;
                pend_v[s] = 1;
                if (cmd[s] == 3'b001) begin
                    w = mdl[addr[s][3:0]];
                    for (int i = 0; i < BW; i++)
                        if (be[s][i]) w[8*i +: 8] = wdat[s][8*i +: 8];
                    mdl[addr[s][3:0]] = w;
                end else begin
                    pend_d[s] = mdl[addr[s][3:0]];
                end
            end
        end
        @(posedge clk);
        cyc = in_rst ? 0 : cyc + 1;
        #1;
        for (int k = 0; k < NC; k++) begin
            if (k == last_acc) begin
                if (rnd_mode) new_req(k);
                else cmd[k] = 3'b000;
            end else if (rnd_mode && !valid_cmd(cmd[k]) && $urandom_range(0, 1) == 1) begin
                new_req(k);
            end
        end
    endtask

    task automatic issue(int k, logic [2:0] c, logic [AW-1:0] a,
                         logic [DW-1:0] d, logic [BW-1:0] b);
        bit done;
        cmd[k] = c;
        addr[k] = a;
        wdat[k] = d;
        be[k] = b;
        done = 0;
        for (int i = 0; i < 2 * NC && !done; i++) begin
            step();
            if (last_acc == k) done = 1;
        end
        if (!done) chk($sformatf("timeout_p%0d", k), 64'd0, 64'd1);
    endtask

    task automatic go_slot(int s);
        for (int i = 0; i < NC && (cyc % NC) != s; i++) step();
    endtask

    initial begin
        int lat;
        for (int k = 0; k < NC; k++) begin
            cmd[k] = '0;
            addr[k] = '0;
            wdat[k] = '0;
            be[k] = '0;
            pend_v[k] = 0;
            pend_d[k] = '0;
        end
        reset = 1'b0;
        #1;
        step();
        step();
        reset = 1'b1;

        for (int a = 0; a < 16; a++) issue(0, 3'b001, AW'(a), $urandom, 4'hF);

        // Write in slot 0, read-back by port 1 in the very next slot.
        go_slot(0);
        cmd[0] = 3'b001; addr[0] = 10'h005; wdat[0] = 32'hDEADBEEF; be[0] = 4'hF;
        cmd[1] = 3'b010; addr[1] = 10'h005; be[1] = 4'h0;
        step();
        step();
        chk("wr_dva_p0", 64'(obs_v[0]), 64'd1);
        chk("wr_data_p0", 64'(obs_d[0]), 64'd0);
        step();
        chk("raw_dva_p1", 64'(obs_v[1]), 64'd1);
        chk("raw_data_p1", 64'(obs_d[1]), 64'hDEADBEEF);

        issue(2, 3'b001, 10'h005, 32'h11223344, 4'b0101);
        issue(2, 3'b010, 10'h005, 32'h0, 4'h0);
        step();
        chk("merge_p2", 64'(obs_d[2]), 64'hDE22BE44);

        // All ports read at once from slot 0; port 2 waits longest.
        go_slot(0);
        for (int k = 0; k < NC; k++) begin
            cmd[k] = 3'b010; addr[k] = 10'h005;
        end
        lat = -1;
        for (int i = 1; i <= 8 && lat < 0; i++) begin
            step();
            if (obs_v[2]) lat = i - 1;
        end
        chk("lat_p2", 64'(lat), 64'd3);

        cmd[1] = 3'b011;
        for (int i = 0; i < 6; i++) step();
        cmd[1] = 3'b000;

        // Reset during the accept cycle, then during a pending response.
        go_slot(0);
        cmd[0] = 3'b001; addr[0] = 10'h005; wdat[0] = 32'hCAFEF00D; be[0] = 4'hF;
        reset = 1'b0;
        step();
        cmd[0] = 3'b000;
        reset = 1'b1;
        issue(0, 3'b010, 10'h005, 32'h0, 4'h0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("no_dva_p0", 64'(obs_v[0]), 64'd0);
        issue(1, 3'b010, 10'h005, 32'h0, 4'h0);
        step();
        chk("mem_kept", 64'(obs_d[1]), 64'hDE22BE44);

        rnd_mode = 1;
        for (int k = 0; k < NC; k++) new_req(k);
        for (int i = 0; i < 400; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
